// File: rtl/stage_ex.sv
// Execute stage: single-cycle ALU, branch resolution and multiply, plus a
// 32-iteration restoring divider that stalls upstream while it runs.
module stage_ex (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] busa_in,
  input  logic [31:0] busb_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  op_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd_in,
  input  logic        ras_ena_in,
  output logic [31:0] alu_out,
  output logic [31:0] busb_out,
  output logic [4:0]  rd_out,
  output logic [6:0]  op_out,
  output logic [2:0]  funct3_out,
  output logic        ras_ena_out,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic        stall_int;

  // Decode
  logic [6:0]  funct7;
  logic        is_muldiv, is_base_op, div_op, div_signed, div_zero, div_ovf, div_start;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign funct7     = imm_in[11:5];
  assign is_muldiv  = (op_in == OpcOp) && (funct7 == 7'b0000001);
  assign is_base_op = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
  assign div_op     = is_muldiv && funct3_in[2];
  assign div_signed = ~funct3_in[0];
  assign div_zero   = (busb_in == 32'd0);
  assign div_ovf    = div_signed && (busa_in == 32'h8000_0000) && (busb_in == 32'hFFFF_FFFF);
  assign div_start  = div_op && !div_zero && !div_ovf;
  assign a_neg      = div_signed & busa_in[31];
  assign b_neg      = div_signed & busb_in[31];
  assign a_mag      = a_neg ? 32'd0 - busa_in : busa_in;
  assign b_mag      = b_neg ? 32'd0 - busb_in : busb_in;

  // ALU
  logic [31:0] op_b, sra_res, alu_res;
  logic [4:0]  shamt;
  logic        alt, is_sub;

  assign op_b    = (op_in == OpcOpImm) ? imm_in : busb_in;
  assign shamt   = op_b[4:0];
  assign alt     = imm_in[10];
  assign is_sub  = (op_in == OpcOp) && alt;
  assign sra_res = $unsigned($signed(busa_in) >>> shamt);

  always_comb begin
    alu_res = '0;
    case (funct3_in)
      3'b000:  alu_res = is_sub ? busa_in - op_b : busa_in + op_b;
      3'b001:  alu_res = busa_in << shamt;
      3'b010:  alu_res = {31'd0, $signed(busa_in) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, busa_in < op_b};
      3'b100:  alu_res = busa_in ^ op_b;
      3'b101:  alu_res = alt ? sra_res : busa_in >> shamt;
      3'b110:  alu_res = busa_in | op_b;
      3'b111:  alu_res = busa_in & op_b;
      default: alu_res = '0;
    endcase
  end

  // Multiply: sign-extend to 64 bits so the low 64 bits of the product are exact
  logic        mul_a_sgn, mul_b_sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] mul_res;

  assign mul_a_sgn = (funct3_in[1:0] != 2'b11) & busa_in[31];
  assign mul_b_sgn = (funct3_in[1:0] == 2'b01) & busb_in[31];
  assign mul_a     = {{32{mul_a_sgn}}, busa_in};
  assign mul_b     = {{32{mul_b_sgn}}, busb_in};
  assign prod      = mul_a * mul_b;
  assign mul_res   = (funct3_in[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

  // Divide results: bypass cases and sign fix-up of the FSM result
  logic [31:0] div_bypass, div_q_fix, div_r_fix, div_res;

  always_comb begin
    if (div_zero) div_bypass = funct3_in[1] ? busa_in : 32'hFFFF_FFFF;
    else          div_bypass = funct3_in[1] ? 32'd0   : 32'h8000_0000;
  end

  assign div_q_fix = (a_neg ^ b_neg) ? 32'd0 - quot_q : quot_q;
  assign div_r_fix = a_neg ? 32'd0 - rem_q : rem_q;
  assign div_res   = funct3_in[1] ? div_r_fix : div_q_fix;

  // Divider FSM: dividend shifts out of quot_q while quotient bits shift in
  logic [32:0] shifted, diff;

  assign shifted = {rem_q, quot_q[31]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    stall_int = 1'b0;
    case (state_q)
      StIdle: begin
        if (div_start) begin
          stall_int = 1'b1;
          state_d   = StDiv;
          count_d   = 5'd0;
          rem_d     = 32'd0;
          quot_d    = a_mag;
          dvsr_d    = b_mag;
        end
      end
      StDiv: begin
        stall_int = 1'b1;
        count_d   = count_q + 5'd1;
        if (!diff[32]) begin
          rem_d  = diff[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        if (count_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reset must silence stall even when a divide is sitting at the input
  assign stall = stall_int & rst_n;

  // Output register next-state
  logic        valid;
  logic [31:0] alu_d, busb_d, target_d;
  logic        taken_d, cond;

  always_comb begin
    case (funct3_in)
      3'b000:  cond = (busa_in == busb_in);
      3'b001:  cond = (busa_in != busb_in);
      3'b100:  cond = ($signed(busa_in) < $signed(busb_in));
      3'b101:  cond = ($signed(busa_in) >= $signed(busb_in));
      3'b110:  cond = (busa_in < busb_in);
      3'b111:  cond = (busa_in >= busb_in);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    valid    = 1'b0;
    alu_d    = '0;
    busb_d   = '0;
    taken_d  = 1'b0;
    target_d = '0;
    if (!stall_int) begin
      case (op_in)
        OpcOp: begin
          if (state_q == StDone) begin
            valid = 1'b1;
            alu_d = div_res;
          end else if (is_muldiv) begin
            valid = 1'b1;
            alu_d = funct3_in[2] ? div_bypass : mul_res;
          end else if (is_base_op) begin
            valid = 1'b1;
            alu_d = alu_res;
          end
        end
        OpcOpImm: begin
          valid = 1'b1;
          alu_d = alu_res;
        end
        OpcLui: begin
          valid = 1'b1;
          alu_d = imm_in;
        end
        OpcAuipc: begin
          valid = 1'b1;
          alu_d = pc_in + imm_in;
        end
        OpcJal: begin
          valid    = 1'b1;
          alu_d    = pc_in + 32'd4;
          taken_d  = 1'b1;
          target_d = pc_in + imm_in;
        end
        OpcJalr: begin
          valid    = 1'b1;
          alu_d    = pc_in + 32'd4;
          taken_d  = 1'b1;
          target_d = (busa_in + imm_in) & 32'hFFFF_FFFE;
        end
        OpcBranch: begin
          valid    = 1'b1;
          taken_d  = cond;
          target_d = pc_in + imm_in;
        end
        OpcLoad, OpcStore: begin
          valid  = 1'b1;
          alu_d  = busa_in + imm_in;
          busb_d = busb_in;
        end
        default: valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      dvsr_q        <= '0;
      alu_out       <= '0;
      busb_out      <= '0;
      rd_out        <= '0;
      op_out        <= '0;
      funct3_out    <= '0;
      ras_ena_out   <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      quot_q        <= quot_d;
      dvsr_q        <= dvsr_d;
      alu_out       <= alu_d;
      busb_out      <= busb_d;
      rd_out        <= valid ? rd_in : 5'd0;
      op_out        <= valid ? op_in : 7'd0;
      funct3_out    <= valid ? funct3_in : 3'd0;
      ras_ena_out   <= valid & ras_ena_in;
      branch_taken  <= taken_d;
      branch_target <= target_d;
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: vector table for single-cycle ops, hand-written
// sequences for the divider, its stall window and reset abort.
module tb_stage_ex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] busa_in, busb_in, imm_in, pc_in;
  logic [2:0]  funct3_in;
  logic [6:0]  op_in;
  logic [4:0]  rd_in;
  logic        ras_ena_in;
  logic [31:0] alu_out, busb_out, branch_target;
  logic [4:0]  rd_out;
  logic [6:0]  op_out;
  logic [2:0]  funct3_out;
  logic        ras_ena_out, branch_taken, stall;

  int total = 0;
  int bad   = 0;

  stage_ex dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .busa_in       (busa_in),
    .busb_in       (busb_in),
    .imm_in        (imm_in),
    .funct3_in     (funct3_in),
    .op_in         (op_in),
    .pc_in         (pc_in),
    .rd_in         (rd_in),
    .ras_ena_in    (ras_ena_in),
    .alu_out       (alu_out),
    .busb_out      (busb_out),
    .rd_out        (rd_out),
    .op_out        (op_out),
    .funct3_out    (funct3_out),
    .ras_ena_out   (ras_ena_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, imm, pc;
    logic [31:0] e_alu, e_busb;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_valid;
  } vec_t;

  vec_t  vecs[$];
  string names[$];

  task automatic add(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] a, b, imm, pc, e_alu, e_busb,
                     input logic e_tk, input logic [31:0] e_tgt, input logic e_valid);
    vec_t v;
    v.op = op; v.f3 = f3; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.e_alu = e_alu; v.e_busb = e_busb; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_valid = e_valid;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit outs_zero();
    return (alu_out == 0) && (busb_out == 0) && (rd_out == 0) && (op_out == 0) &&
           (funct3_out == 0) && !ras_ena_out && !branch_taken && (branch_target == 0);
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, b, imm, pc, input logic [4:0] rd, input logic ras);
    op_in = op; funct3_in = f3; busa_in = a; busb_in = b; imm_in = imm; pc_in = pc;
    rd_in = rd; ras_ena_in = ras;
  endtask

  // Divide that must go through the FSM: 33 stall cycles, bubbles, then the result
  task automatic run_div(input string nm, input logic [31:0] a, b, input logic [2:0] f3,
                         input logic [31:0] exp);
    int  cnt;
    bit  zero_ok;
    cnt = 0;
    zero_ok = 1'b1;
    drive(7'h33, f3, a, b, 32'h20, 32'h0, 5'd9, 1'b1);
    #1;
    while (stall && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
      if (!outs_zero()) zero_ok = 1'b0;
    end
    chk({nm, "_stall_cycles"}, cnt, 33);
    chk({nm, "_bubbles"}, {31'd0, zero_ok}, 1);
    @(posedge clk); #1;
    chk({nm, "_result"}, alu_out, exp);
    chk({nm, "_rd"}, {27'd0, rd_out}, 9);
    chk({nm, "_ras"}, {31'd0, ras_ena_out}, 1);
    drive(7'h0, 3'd0, 0, 0, 0, 0, 5'd0, 1'b0);
  endtask

  localparam logic [6:0] OP = 7'h33, IMM = 7'h13, BR = 7'h63;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add("add",    OP, 0, 5, 7, 0, 0, 12, 0, 0, 0, 1);
    add("sub",    OP, 0, 5, 7, 32'h400, 0, 32'hFFFFFFFE, 0, 0, 0, 1);
    add("sll",    OP, 1, 1, 35, 0, 0, 8, 0, 0, 0, 1);
    add("slt",    OP, 2, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0, 1);
    add("sltu",   OP, 3, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 1);
    add("xor",    OP, 4, 32'hF0F0, 32'h0FF0, 0, 0, 32'hFF00, 0, 0, 0, 1);
    add("srl",    OP, 5, 32'h80000000, 4, 0, 0, 32'h08000000, 0, 0, 0, 1);
    add("sra",    OP, 5, 32'h80000000, 4, 32'h400, 0, 32'hF8000000, 0, 0, 0, 1);
    add("or",     OP, 6, 32'hF0, 32'h0F, 0, 0, 32'hFF, 0, 0, 0, 1);
    add("and",    OP, 7, 32'hF0, 32'h3C, 0, 0, 32'h30, 0, 0, 0, 1);
    add("addi",   IMM, 0, 10, 32'h55, 32'hFFFFFFFF, 0, 9, 0, 0, 0, 1);
    add("addi10", IMM, 0, 1, 0, 32'h400, 0, 32'h401, 0, 0, 0, 1);
    add("srli",   IMM, 5, 32'h80000000, 0, 4, 0, 32'h08000000, 0, 0, 0, 1);
    add("srai",   IMM, 5, 32'h80000000, 0, 32'h404, 0, 32'hF8000000, 0, 0, 0, 1);
    add("slti",   IMM, 2, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 1);
    add("lui",    7'h37, 0, 0, 0, 32'h12345000, 0, 32'h12345000, 0, 0, 0, 1);
    add("auipc",  7'h17, 0, 0, 0, 32'h2000, 32'h1000, 32'h3000, 0, 0, 0, 1);
    add("jal",    7'h6F, 0, 0, 0, 32'h40, 32'h100, 32'h104, 0, 1, 32'h140, 1);
    add("jalr",   7'h67, 0, 32'h203, 0, 0, 32'h50, 32'h54, 0, 1, 32'h202, 1);
    add("beq_t",  BR, 0, 3, 3, 32'h20, 32'h100, 0, 0, 1, 32'h120, 1);
    add("beq_n",  BR, 0, 3, 4, 32'h20, 32'h100, 0, 0, 0, 32'h120, 1);
    add("bne",    BR, 1, 3, 4, 32'h20, 32'h100, 0, 0, 1, 32'h120, 1);
    add("blt",    BR, 4, 32'hFFFFFFFF, 1, 8, 0, 0, 0, 1, 8, 1);
    add("bge",    BR, 5, 32'hFFFFFFFF, 1, 8, 0, 0, 0, 0, 8, 1);
    add("bltu",   BR, 6, 32'hFFFFFFFF, 1, 8, 0, 0, 0, 0, 8, 1);
    add("bgeu",   BR, 7, 32'hFFFFFFFF, 1, 8, 0, 0, 0, 1, 8, 1);
    add("load",   7'h03, 2, 32'h1000, 32'hAB, 32'hFFFFFFFC, 0, 32'hFFC, 32'hAB, 0, 0, 1);
    add("store",  7'h23, 2, 32'h200, 32'hDEADBEEF, 8, 0, 32'h208, 32'hDEADBEEF, 0, 0, 1);
    add("mul",    OP, 0, 6, 7, 32'h20, 0, 42, 0, 0, 0, 1);
    add("mulh",   OP, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20, 0, 0, 0, 0, 0, 1);
    add("mulh2",  OP, 1, 32'hFFFFFFFF, 2, 32'h20, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    add("mulhsu", OP, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    add("mulhu",  OP, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20, 0, 32'hFFFFFFFE, 0, 0, 0, 1);
    add("divu0",  OP, 5, 32'h4D2, 0, 32'h20, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    add("remu0",  OP, 7, 32'h4D2, 0, 32'h20, 0, 32'h4D2, 0, 0, 0, 1);
    add("div0",   OP, 4, 32'h4D2, 0, 32'h20, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
    add("divovf", OP, 4, 32'h80000000, 32'hFFFFFFFF, 32'h20, 0, 32'h80000000, 0, 0, 0, 1);
    add("removf", OP, 6, 32'h80000000, 32'hFFFFFFFF, 32'h20, 0, 0, 0, 0, 0, 1);
    add("bubble", 7'h00, 3, 1, 2, 3, 4, 0, 0, 0, 0, 0);
    add("badop",  7'h7F, 3, 1, 2, 3, 4, 0, 0, 0, 0, 0);
    add("badf7",  OP, 0, 5, 7, 32'h40, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(7'h0, 3'd0, 0, 0, 0, 0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs_zero", {31'd0, outs_zero()}, 1);
    chk("reset_stall", {31'd0, stall}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      logic [4:0] rd;
      logic       ras;
      rd  = 5'(i % 31 + 1);
      ras = i[0];
      drive(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, rd, ras);
      #1;
      chk({names[i], "_stall"}, {31'd0, stall}, 0);
      @(posedge clk); #1;
      chk({names[i], "_alu"}, alu_out, vecs[i].e_alu);
      chk({names[i], "_busb"}, busb_out, vecs[i].e_busb);
      chk({names[i], "_taken"}, {31'd0, branch_taken}, {31'd0, vecs[i].e_tk});
      chk({names[i], "_target"}, branch_target, vecs[i].e_tgt);
      chk({names[i], "_rd"}, {27'd0, rd_out}, vecs[i].e_valid ? {27'd0, rd} : 32'd0);
      chk({names[i], "_op"}, {25'd0, op_out}, vecs[i].e_valid ? {25'd0, vecs[i].op} : 32'd0);
      chk({names[i], "_f3"}, {29'd0, funct3_out}, vecs[i].e_valid ? {29'd0, vecs[i].f3} : 32'd0);
      chk({names[i], "_ras"}, {31'd0, ras_ena_out}, vecs[i].e_valid ? {31'd0, ras} : 32'd0);
    end

    run_div("div_m7_2",   32'hFFFFFFF9, 2, 3'b100, 32'hFFFFFFFD);
    run_div("rem_m7_2",   32'hFFFFFFF9, 2, 3'b110, 32'hFFFFFFFF);
    run_div("div_m7_m2",  32'hFFFFFFF9, 32'hFFFFFFFE, 3'b100, 3);
    run_div("divu_big_3", 32'hFFFFFFFF, 3, 3'b101, 32'h55555555);

    // Reset while outputs hold a live result clears them at once
    drive(OP, 3'd0, 5, 7, 0, 0, 5'd3, 1'b1);
    @(posedge clk); #1;
    chk("pre_reset_alu", alu_out, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs_zero", {31'd0, outs_zero()}, 1);
    #2 rst_n = 1'b1;

    // Abort a divide mid-iteration, then reissue it from scratch
    drive(OP, 3'b101, 100, 7, 32'h20, 0, 5'd9, 1'b1);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_stall_low", {31'd0, stall}, 0);
    chk("abort_outs_zero", {31'd0, outs_zero()}, 1);
    @(posedge clk); #1;
    chk("abort_stall_held_low", {31'd0, stall}, 0);
    rst_n = 1'b1;
    run_div("divu_100_7", 100, 7, 3'b101, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
